// File: rtl/rom_arbiter_8ch_pkg.sv
// Shared constants and helpers for the 8-channel ROM read arbiter.
package rom_arb_pkg;

  localparam int unsigned NUM_CH      = 8;
  localparam int unsigned CH_IDX_W    = 3;
  localparam int unsigned ROM_LATENCY = 1;
  localparam int unsigned PIPE_DEPTH  = 2;

  // One-hot to binary index; an all-zero input maps to index 0.
  function automatic logic [CH_IDX_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
    logic [CH_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (oh[i]) idx = idx | CH_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rom_arbiter_8ch_if.sv
// Requester/ROM-side bundle of the 8-channel ROM read arbiter.
interface rom_arbiter_8ch_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8
);
  import rom_arb_pkg::*;

  logic [NUM_CH-1:0]            i_ch_en;
  logic [NUM_CH-1:0]            i_req;
  logic [NUM_CH*ADDR_WIDTH-1:0] i_addr;
  logic [NUM_CH-1:0]            o_ack;
  logic                         o_rom_en;
  logic [ADDR_WIDTH-1:0]        o_rom_addr;
  logic [DATA_WIDTH-1:0]        i_rom_data;
  logic [DATA_WIDTH-1:0]        o_data;
  logic [NUM_CH-1:0]            o_valid;
  logic                         o_busy;

  modport slave (
    input  i_ch_en, i_req, i_addr, i_rom_data,
    output o_ack, o_rom_en, o_rom_addr, o_data, o_valid, o_busy
  );

  modport master (
    output i_ch_en, i_req, i_addr, i_rom_data,
    input  o_ack, o_rom_en, o_rom_addr, o_data, o_valid, o_busy
  );

endinterface

// File: rtl/rom_arbiter_8ch_rr_pick.sv
// Rotate-priority picker: first eligible channel at or after ptr, wrapping 7->0.
module rr_pick_8
  import rom_arb_pkg::*;
(
  input  logic [NUM_CH-1:0]   elig_i,
  input  logic [CH_IDX_W-1:0] ptr_i,
  output logic [NUM_CH-1:0]   grant_c_o,
  output logic [CH_IDX_W-1:0] idx_c_o,
  output logic                any_c_o
);

  logic [2*NUM_CH-1:0] rot_dbl_c;
  logic [2*NUM_CH-1:0] back_dbl_c;
  logic [NUM_CH-1:0]   rot_c;
  logic [NUM_CH-1:0]   first_c;

  // Rotate so ptr sits at bit 0, isolate lowest set bit, rotate back.
  always_comb begin
    rot_dbl_c  = {elig_i, elig_i} >> ptr_i;
    rot_c      = rot_dbl_c[NUM_CH-1:0];
    first_c    = rot_c & (~rot_c + NUM_CH'(1));
    back_dbl_c = {first_c, first_c} << ptr_i;
    grant_c_o  = back_dbl_c[2*NUM_CH-1:NUM_CH];
    idx_c_o    = onehot_to_idx(grant_c_o);
    any_c_o    = |elig_i;
  end

endmodule

// File: rtl/rom_arbiter_8ch.sv
// Round-robin arbiter sharing one registered-output ROM read port among 8 channels.
module rom_arbiter_8ch
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic               i_clk,
  input logic               i_rst,
  rom_arbiter_8ch_if.slave  bus
);

  logic [NUM_CH-1:0]     elig_c;
  logic [NUM_CH-1:0]     grant_c;
  logic [CH_IDX_W-1:0]   idx_c;
  logic                  any_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;

  logic [CH_IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0]     ack_q;
  logic [NUM_CH-1:0]     tag1_q;
  logic [NUM_CH-1:0]     tag2_q;
  logic [NUM_CH-1:0]     valid_q;
  logic                  rom_en_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;

  // Last cycle's winner is masked so a requester still dropping req is not re-granted.
  assign elig_c = bus.i_req & bus.i_ch_en & ~ack_q;

  rr_pick_8 u_pick (
    .elig_i    (elig_c),
    .ptr_i     (ptr_q),
    .grant_c_o (grant_c),
    .idx_c_o   (idx_c),
    .any_c_o   (any_c)
  );

  always_comb begin
    sel_addr_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (grant_c[k]) sel_addr_c = bus.i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    data_d     = data_q;
    if (any_c) begin
      ptr_d      = idx_c + CH_IDX_W'(1);
      rom_addr_d = sel_addr_c;
    end
    if (|tag2_q) data_d = bus.i_rom_data;
    // Busy mirrors the tag registers as they will be after this edge.
    busy_d = (|grant_c) | (|tag1_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q      <= '0;
      ack_q      <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
      valid_q    <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      ack_q      <= grant_c;
      tag1_q     <= grant_c;
      tag2_q     <= tag1_q;
      valid_q    <= tag2_q;
      rom_en_q   <= any_c;
      rom_addr_q <= rom_addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_ack      = ack_q;
  assign bus.o_rom_en   = rom_en_q;
  assign bus.o_rom_addr = rom_addr_q;
  assign bus.o_data     = data_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_busy     = busy_q;

endmodule

// File: tb/tb_rom_arbiter_8ch.sv
// Bench for rom_arbiter_8ch: queue-based reference model plus directed literal checks.
module tb_rom_arbiter_8ch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_arbiter_8ch_if #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) bif ();
  rom_arbiter_8ch #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bif)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [512];
  logic [8:0] addr [8];
  logic [7:0] req_v, en_v;

  // Single-port ROM, registered output, one-cycle latency.
  logic [7:0] rom_q = 8'h00;
  always @(posedge clk) if (bif.o_rom_en) rom_q <= mem[bif.o_rom_addr];
  assign bif.i_rom_data = rom_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bif.i_req   = req_v;
    bif.i_ch_en = en_v;
    for (int k = 0; k < 8; k++) bif.i_addr[k*9 +: 9] = addr[k];
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: pending returns are a queue of (due cycle, tag, data).
  typedef struct {
    int         due;
    logic [7:0] oh;
    logic [7:0] data;
  } ret_t;
  ret_t pend[$];

  int         cyc = 0;
  int         m_ptr = 0;
  int         win;
  int         j;
  logic [7:0] elig;
  logic [7:0] m_ack = '0, m_valid = '0, m_data = '0;
  logic       m_rom_en = 1'b0, m_busy = 1'b0;
  logic [8:0] m_rom_addr = '0;
  ret_t       r;

  always begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_ptr = 0; m_ack = '0; m_valid = '0; m_data = '0;
      m_rom_en = 1'b0; m_busy = 1'b0; m_rom_addr = '0;
      pend.delete();
    end else begin
      elig = bif.i_req & bif.i_ch_en & ~m_ack;
      win = -1;
      for (int i = 0; i < 8; i++) begin
        j = (m_ptr + i) % 8;
        if (win < 0 && elig[j]) win = j;
      end
      m_valid = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_valid = pend[0].oh;
        m_data  = pend[0].data;
        void'(pend.pop_front());
      end
      if (win >= 0) begin
        m_ack      = 8'(1) << win;
        m_rom_en   = 1'b1;
        m_rom_addr = bif.i_addr[win*9 +: 9];
        r.due = cyc + 2; r.oh = m_ack; r.data = mem[m_rom_addr];
        pend.push_back(r);
        m_ptr = (win + 1) % 8;
      end else begin
        m_ack    = '0;
        m_rom_en = 1'b0;
      end
      m_busy = (pend.size() != 0);
    end
    #1;
    chk("model_ack",      32'(bif.o_ack),      32'(m_ack));
    chk("model_rom_en",   32'(bif.o_rom_en),   32'(m_rom_en));
    chk("model_rom_addr", 32'(bif.o_rom_addr), 32'(m_rom_addr));
    chk("model_valid",    32'(bif.o_valid),    32'(m_valid));
    chk("model_data",     32'(bif.o_data),     32'(m_data));
    chk("model_busy",     32'(bif.o_busy),     32'(m_busy));
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ ((i >= 256) ? 8'hFF : 8'h00);
    for (int k = 0; k < 8; k++) addr[k] = 9'(k*37 + 5);
    rst = 1'b1; req_v = 8'hFF; en_v = 8'hFF; drive();

    // Reset held with all requesting.
    step(3);
    chk("rst_ack",   32'(bif.o_ack),   32'h00);
    chk("rst_valid", 32'(bif.o_valid), 32'h00);
    chk("rst_busy",  32'(bif.o_busy),  32'h0);
    chk("rst_romen", 32'(bif.o_rom_en), 32'h0);
    rst = 1'b0;
    step(1);
    chk("first_ack", 32'(bif.o_ack), 32'h01);
    req_v = 8'h00; drive();
    step(2);
    chk("first_valid", 32'(bif.o_valid), 32'h01);
    chk("first_data",  32'(bif.o_data),  32'h05);
    step(1);

    // Single request from ch3.
    addr[3] = 9'h055; req_v = 8'h08; drive();
    step(1);
    chk("single_ack",   32'(bif.o_ack),  32'h08);
    chk("single_busy1", 32'(bif.o_busy), 32'h1);
    req_v = 8'h00; drive();
    step(1);
    chk("single_ack0",  32'(bif.o_ack),  32'h00);
    chk("single_busy2", 32'(bif.o_busy), 32'h1);
    step(1);
    chk("single_valid", 32'(bif.o_valid), 32'h08);
    chk("single_data",  32'(bif.o_data),  32'h55);
    chk("single_busy3", 32'(bif.o_busy),  32'h0);
    step(1);
    chk("single_valid0", 32'(bif.o_valid), 32'h00);

    // All eight requesting continuously from ptr=0.
    rst = 1'b1; step(1); rst = 1'b0;
    req_v = 8'hFF; drive();
    for (int i = 0; i < 16; i++) begin
      step(1);
      chk("rot_ack", 32'(bif.o_ack), 32'(8'(1) << (i % 8)));
      if (i >= 2) chk("rot_valid", 32'(bif.o_valid), 32'(8'(1) << ((i - 2) % 8)));
    end
    req_v = 8'h00; drive(); step(3);

    // Only upper four channels enabled.
    en_v = 8'hF0; req_v = 8'hFF; drive();
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("en_ack_lo",   32'(bif.o_ack & 8'h0F),   32'h0);
      chk("en_ack_any",  32'(bif.o_ack != 8'h00),  32'h1);
      chk("en_valid_lo", 32'(bif.o_valid & 8'h0F), 32'h0);
    end
    req_v = 8'h00; en_v = 8'hFF; drive(); step(3);

    // ch2 disabled right after its grant: in-flight read still returns.
    addr[2] = 9'h1A3; req_v = 8'h04; drive();
    for (int t = 0; t < 10 && bif.o_ack != 8'h04; t++) step(1);
    chk("dis_wait_ack", 32'(bif.o_ack), 32'h04);
    en_v = 8'hFB; drive();
    step(1);
    chk("dis_ack0", 32'(bif.o_ack), 32'h00);
    step(1);
    chk("dis_valid", 32'(bif.o_valid), 32'h04);
    chk("dis_data",  32'(bif.o_data),  32'h5C);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("dis_no_ack", 32'(bif.o_ack), 32'h00);
    end
    req_v = 8'h00; en_v = 8'hFF; drive(); step(3);

    // Reset one cycle after the ch5 grant discards its return.
    req_v = 8'hFF; drive();
    for (int t = 0; t < 20 && bif.o_ack != 8'h20; t++) step(1);
    chk("mid_wait_ack5", 32'(bif.o_ack), 32'h20);
    step(1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bif.o_valid), 32'h00);
    chk("mid_rst_busy",  32'(bif.o_busy),  32'h0);
    step(1);
    chk("mid_rst_valid2", 32'(bif.o_valid), 32'h00);
    step(1);
    rst = 1'b0;
    step(1);
    chk("mid_restart_ack", 32'(bif.o_ack), 32'h01);
    chk("mid_no_valid5",   32'(bif.o_valid), 32'h00);
    req_v = 8'h00; drive(); step(3);

    // Randomized requesters with occasional enable changes and resets.
    for (int n = 0; n < 3000; n++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
        if (req_v[k] && bif.o_ack[k]) begin
          req_v[k] = 1'($urandom_range(0, 1));
          addr[k]  = 9'($urandom_range(0, 511));
        end else if (req_v[k]) begin
          if ($urandom_range(0, 19) == 0) req_v[k] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          req_v[k] = 1'b1;
          addr[k]  = 9'($urandom_range(0, 511));
        end
      end
      if ($urandom_range(0, 31) == 0) en_v = 8'($urandom);
      drive();
      step(1);
    end
    rst = 1'b0; req_v = 8'h00; drive();
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
